// File: rtl/fu_tracker_pkg.sv
// Shared types and sizing for the functional-unit tracker.
// FU counts per class and the index width live here as macros.
`ifndef FU_TRACKER_PKG_MACROS
`define FU_TRACKER_PKG_MACROS
`define NUM_FU_ALU    3
`define NUM_FU_MULT   2
`define NUM_FU_LOAD   1
`define NUM_FU_STORE  1
`define NUM_FU_BRANCH 1
`define MAX_FU_INDEX  2
`endif

package fu_tracker_pkg;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    MULT   = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4
  } func_type_e;

  localparam int N_CLS = 5;

  function automatic int max5(
    input int a, input int b, input int c,
    input int d, input int e
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/fu_tracker_if.sv
// Issue/complete-side bundle for fu_tracker.
// master = issue/complete logic, slave = tracker.
interface fu_tracker_if #(
  parameter int N_ALU    = `NUM_FU_ALU,
  parameter int N_MULT   = `NUM_FU_MULT,
  parameter int N_LOAD   = `NUM_FU_LOAD,
  parameter int N_STORE  = `NUM_FU_STORE,
  parameter int N_BRANCH = `NUM_FU_BRANCH,
  parameter int IDX_W    = `MAX_FU_INDEX,
  parameter int CNT_W    = 2
);
  logic [4:0]            req_valid;
  logic [4:0]            grant;
  logic [4:0][IDX_W-1:0] grant_idx;
  logic [N_ALU-1:0]      free_alu;
  logic [N_MULT-1:0]     free_mult;
  logic [N_LOAD-1:0]     free_load;
  logic [N_STORE-1:0]    free_store;
  logic [N_BRANCH-1:0]   free_branch;
  logic [4:0][CNT_W-1:0] avail_cnt;
  logic                  free_err;

  modport master (
    output req_valid, free_alu, free_mult,
    output free_load, free_store, free_branch,
    input  grant, grant_idx, avail_cnt, free_err
  );

  modport slave (
    input  req_valid, free_alu, free_mult,
    input  free_load, free_store, free_branch,
    output grant, grant_idx, avail_cnt, free_err
  );
endinterface

// File: rtl/fu_tracker_pool.sv
// One FU class: busy bits, round-robin grant from rr_ptr,
// idle count and sticky error for frees of idle units.
module fu_pool #(
  parameter int N     = 1,
  parameter int IDX_W = 1,
  parameter int CNT_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic [N-1:0]     i_free,
  output logic             o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_err
);
  logic [N-1:0]     r_busy;
  logic [IDX_W-1:0] r_ptr;
  logic             r_err;

  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [N-1:0]     w_set;
  int               w_j;
  int               w_cnt;

  // Scan from r_ptr with wrap; first idle unit wins.
  always_comb begin
    w_found   = 1'b0;
    w_idx     = '0;
    w_ptr_nxt = r_ptr;
    w_set     = '0;
    w_j       = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!w_found && !r_busy[w_j]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(w_j);
        w_ptr_nxt = (w_j == N - 1) ? '0
                                   : IDX_W'(w_j + 1);
        w_set[w_j] = i_req;
      end
    end
  end

  always_comb begin
    w_cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (!r_busy[i]) w_cnt = w_cnt + 1;
    end
  end

  assign o_grant = i_req && w_found;
  assign o_idx   = o_grant ? w_idx : '0;
  assign o_cnt   = CNT_W'(w_cnt);
  assign o_err   = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
      r_ptr  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~i_free) | w_set;
      if (|(i_free & ~r_busy)) r_err <= 1'b1;
      if (o_grant) r_ptr <= w_ptr_nxt;
    end
  end
endmodule

// File: rtl/fu_tracker.sv
// Issue-side FU busy tracker: one round-robin pool per class,
// all classes independent and grantable in the same cycle.
module fu_tracker
  import fu_tracker_pkg::*;
#(
  parameter int N_ALU    = `NUM_FU_ALU,
  parameter int N_MULT   = `NUM_FU_MULT,
  parameter int N_LOAD   = `NUM_FU_LOAD,
  parameter int N_STORE  = `NUM_FU_STORE,
  parameter int N_BRANCH = `NUM_FU_BRANCH,
  parameter int IDX_W    = `MAX_FU_INDEX
) (
  input logic       clock,
  input logic       reset,
  fu_tracker_if.slave bus
);
  localparam int MAX_N =
    max5(N_ALU, N_MULT, N_LOAD, N_STORE, N_BRANCH);
  localparam int CNT_W = $clog2(MAX_N + 1);

  logic [4:0]            w_grant;
  logic [4:0][IDX_W-1:0] w_idx;
  logic [4:0][CNT_W-1:0] w_cnt;
  logic [4:0]            w_err;

  fu_pool #(.N(N_ALU), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_alu (
    .i_clk(clock), .i_rst(reset),
    .i_req(bus.req_valid[ALU]), .i_free(bus.free_alu),
    .o_grant(w_grant[ALU]), .o_idx(w_idx[ALU]),
    .o_cnt(w_cnt[ALU]), .o_err(w_err[ALU])
  );

  fu_pool #(.N(N_MULT), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_mult (
    .i_clk(clock), .i_rst(reset),
    .i_req(bus.req_valid[MULT]), .i_free(bus.free_mult),
    .o_grant(w_grant[MULT]), .o_idx(w_idx[MULT]),
    .o_cnt(w_cnt[MULT]), .o_err(w_err[MULT])
  );

  fu_pool #(.N(N_LOAD), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_load (
    .i_clk(clock), .i_rst(reset),
    .i_req(bus.req_valid[LOAD]), .i_free(bus.free_load),
    .o_grant(w_grant[LOAD]), .o_idx(w_idx[LOAD]),
    .o_cnt(w_cnt[LOAD]), .o_err(w_err[LOAD])
  );

  fu_pool #(.N(N_STORE), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_store (
    .i_clk(clock), .i_rst(reset),
    .i_req(bus.req_valid[STORE]), .i_free(bus.free_store),
    .o_grant(w_grant[STORE]), .o_idx(w_idx[STORE]),
    .o_cnt(w_cnt[STORE]), .o_err(w_err[STORE])
  );

  fu_pool #(.N(N_BRANCH), .IDX_W(IDX_W), .CNT_W(CNT_W)) u_branch (
    .i_clk(clock), .i_rst(reset),
    .i_req(bus.req_valid[BRANCH]), .i_free(bus.free_branch),
    .o_grant(w_grant[BRANCH]), .o_idx(w_idx[BRANCH]),
    .o_cnt(w_cnt[BRANCH]), .o_err(w_err[BRANCH])
  );

  assign bus.grant     = w_grant;
  assign bus.grant_idx = w_idx;
  assign bus.avail_cnt = w_cnt;
  assign bus.free_err  = |w_err;
endmodule

// File: tb/tb_fu_tracker.sv
// Bench for fu_tracker: directed scenarios plus random issue/free
// traffic against a per-class idle-set reference model.
module tb_fu_tracker;
  import fu_tracker_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fu_tracker_if #(.IDX_W(2), .CNT_W(2)) bus ();

  fu_tracker u_dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int  nfu [5] = '{3, 2, 1, 1, 1};
  bit  mbusy [5][3];
  int  mptr [5];
  bit  merr;

  logic [4:0]      cur_req;
  logic [4:0][2:0] cur_fr;
  logic [4:0]      e_grant;
  int              e_idx [5];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 5; c++) begin
      mptr[c] = 0;
      for (int i = 0; i < 3; i++) mbusy[c][i] = 1'b0;
    end
    merr = 1'b0;
  endfunction

  // Expected outputs from the current model state and requests.
  task automatic drive(input logic [4:0] req,
                       input logic [4:0][2:0] fr);
    logic [4:0][1:0] e_ip;
    logic [4:0][1:0] e_cnt;
    int idle;
    @(negedge clock);
    cur_req = req;
    cur_fr  = fr;
    bus.req_valid   = req;
    bus.free_alu    = fr[0][2:0];
    bus.free_mult   = fr[1][1:0];
    bus.free_load   = fr[2][0:0];
    bus.free_store  = fr[3][0:0];
    bus.free_branch = fr[4][0:0];
    #1;
    if (reset) return;
    for (int c = 0; c < 5; c++) begin
      e_grant[c] = 1'b0;
      e_idx[c]   = 0;
      idle = 0;
      for (int i = 0; i < nfu[c]; i++)
        if (!mbusy[c][i]) idle++;
      e_cnt[c] = 2'(idle);
      if (req[c]) begin
        for (int k = 0; k < nfu[c]; k++) begin
          int j;
          j = (mptr[c] + k) % nfu[c];
          if (!e_grant[c] && !mbusy[c][j]) begin
            e_grant[c] = 1'b1;
            e_idx[c]   = j;
          end
        end
      end
      e_ip[c] = 2'(e_idx[c]);
    end
    chk("grant", 32'(bus.grant), 32'(e_grant));
    chk("grant_idx", 32'(bus.grant_idx), 32'(e_ip));
    chk("avail_cnt", 32'(bus.avail_cnt), 32'(e_cnt));
    chk("free_err", 32'(bus.free_err), 32'(merr));
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < nfu[c]; i++) begin
        if (cur_fr[c][i]) begin
          if (!mbusy[c][i]) merr = 1'b1;
          mbusy[c][i] = 1'b0;
        end
      end
      if (e_grant[c]) begin
        mbusy[c][e_idx[c]] = 1'b1;
        mptr[c] = (e_idx[c] + 1) % nfu[c];
      end
    end
  endtask

  task automatic cyc(input logic [4:0] req,
                     input logic [4:0][2:0] fr);
    drive(req, fr);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    cyc('0, '0);
    cyc('0, '0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [4:0][2:0] zf;
  logic [4:0][2:0] fr;
  int exp_i [4] = '{0, 1, 2, 0};

  initial begin
    zf = '0;
    bus.req_valid = '0;
    bus.free_alu = '0;
    bus.free_mult = '0;
    bus.free_load = '0;
    bus.free_store = '0;
    bus.free_branch = '0;
    e_grant = '0;
    model_reset();
    do_reset();

    // reset state
    drive('0, zf);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_avail", 32'(bus.avail_cnt),
        32'({2'd1, 2'd1, 2'd1, 2'd2, 2'd3}));
    chk("rst_err", 32'(bus.free_err), 32'h0);
    tick();

    // ALU fills up then stalls
    for (int n = 0; n < 4; n++) begin
      drive(5'b00001, zf);
      chk("alu_fill_g", 32'(bus.grant[0]), 32'(n < 3));
      chk("alu_fill_i", 32'(bus.grant_idx[0]),
          32'(exp_i[n]));
      chk("alu_fill_c", 32'(bus.avail_cnt[0]),
          32'(3 - n));
      tick();
    end

    // no same-cycle bypass of a free
    fr = zf; fr[0] = 3'b010;
    drive(5'b00001, fr);
    chk("nobypass", 32'(bus.grant[0]), 32'h0);
    tick();
    drive(5'b00001, zf);
    chk("after_free", 32'(bus.grant_idx[0]), 32'h1);
    chk("after_free_g", 32'(bus.grant[0]), 32'h1);
    tick();

    // round-robin wrap
    do_reset();
    cyc(5'b00001, zf);
    cyc(5'b00001, zf);
    fr = zf; fr[0] = 3'b001;
    cyc('0, fr);
    drive(5'b00001, zf);
    chk("rr_2", 32'(bus.grant_idx[0]), 32'h2);
    tick();
    drive(5'b00001, zf);
    chk("rr_wrap", 32'(bus.grant_idx[0]), 32'h0);
    chk("rr_wrap_g", 32'(bus.grant[0]), 32'h1);
    tick();

    // all classes at once
    do_reset();
    drive(5'b11111, zf);
    chk("all_g", 32'(bus.grant), 32'h1f);
    chk("all_i", 32'(bus.grant_idx), 32'h0);
    tick();
    drive(5'b11111, zf);
    chk("mult_1", 32'(bus.grant_idx[1]), 32'h1);
    chk("load_0", 32'(bus.grant[2]), 32'h0);
    tick();

    // free of an idle unit is sticky until reset
    do_reset();
    fr = zf; fr[1] = 3'b010;
    cyc('0, fr);
    drive('0, zf);
    chk("err_set", 32'(bus.free_err), 32'h1);
    chk("err_mult_cnt", 32'(bus.avail_cnt[1]), 32'h2);
    tick();
    for (int n = 0; n < 3; n++) cyc(5'(n + 3), zf);
    drive('0, zf);
    chk("err_hold", 32'(bus.free_err), 32'h1);
    tick();
    do_reset();
    drive('0, zf);
    chk("err_clr", 32'(bus.free_err), 32'h0);
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      fr = zf;
      for (int c = 0; c < 5; c++)
        for (int i = 0; i < nfu[c]; i++)
          if (mbusy[c][i] && ($urandom % 3 == 0))
            fr[c][i] = 1'b1;
      if ($urandom % 60 == 0) begin
        int c;
        int i;
        c = int'($urandom_range(0, 4));
        i = int'($urandom_range(0, nfu[c] - 1));
        fr[c][i] = 1'b1;
      end
      cyc(5'($urandom), fr);
      if ($urandom % 90 == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
